// File: rtl/spi_frame_writer_if.sv
// Byte-stream input and frame-buffer write bus of spi_frame_writer.
// Optional feature macro: FRAME_CHECKSUM_EN (adds checksum / checksumValid).
interface spi_frame_writer_if #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12
);
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [DATA_W-1:0] byteIn;
  logic              byteStrobe;
  logic              frameAbort;
  logic              frameAck;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              frameReady;
  logic              busy;
  logic              overflow;
`ifdef FRAME_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
  logic              checksumValid;

  modport master (
    output byteIn, byteStrobe, frameAbort, frameAck,
    input  memWe, memAddr, memWdata, col, row, frameReady, busy, overflow,
           checksum, checksumValid
  );
  modport slave (
    input  byteIn, byteStrobe, frameAbort, frameAck,
    output memWe, memAddr, memWdata, col, row, frameReady, busy, overflow,
           checksum, checksumValid
  );
`else
  modport master (
    output byteIn, byteStrobe, frameAbort, frameAck,
    input  memWe, memAddr, memWdata, col, row, frameReady, busy, overflow
  );
  modport slave (
    input  byteIn, byteStrobe, frameAbort, frameAck,
    output memWe, memAddr, memWdata, col, row, frameReady, busy, overflow
  );
`endif
endinterface

// File: rtl/spi_frame_writer.sv
// Writes the SPI byte stream into the frame buffer and hands full frames to the edge core.
// Optional feature macro: FRAME_CHECKSUM_EN (per-frame modulo byte sum).
module spi_frame_writer #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12
) (
  input logic              clk,
  input logic              nRst,
  spi_frame_writer_if.slave bus
);
  localparam int COL_W     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LAST_ADDR = IMG_W * IMG_H - 1;

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              s1, s2, s3;
  logic              byte_evt;
  logic              write_go;
  logic              last_write;
  logic              clear_cnt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [COL_W-1:0]  col_cnt;
  logic [ROW_W-1:0]  row_cnt;

  // byteStrobe is a slow level from the spiClk domain; byteIn is already stable when it rises.
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.byteStrobe;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign byte_evt   = s2 & ~s3;
  assign write_go   = byte_evt & ~bus.frameAbort & (state != FULL);
  assign last_write = write_go & (addr_cnt == ADDR_W'(LAST_ADDR));
  assign clear_cnt  = bus.frameAbort | ((state == FULL) & bus.frameAck);

  always_ff @(posedge clk) begin
    if (!nRst) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: combinational blocks assign a default first so no path leaves a latch behind.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, FILL: begin
        if (bus.frameAbort)  state_nxt = IDLE;
        else if (last_write) state_nxt = FULL;
        else if (write_go)   state_nxt = FILL;
      end
      FULL:    if (bus.frameAbort || bus.frameAck) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy       = (state == FILL);
    bus.frameReady = (state == FULL);
  end

  // Counters hold the next write address; the bus registers hold the address being written.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      bus.memWe    <= 1'b0;
      bus.memAddr  <= '0;
      bus.memWdata <= '0;
      bus.col      <= '0;
      bus.row      <= '0;
      bus.overflow <= 1'b0;
      addr_cnt     <= '0;
      col_cnt      <= '0;
      row_cnt      <= '0;
    end else begin
      bus.memWe <= write_go;
      if (write_go) begin
        bus.memWdata <= bus.byteIn;
        bus.memAddr  <= addr_cnt;
        bus.col      <= col_cnt;
        bus.row      <= row_cnt;
        if (last_write) begin
          addr_cnt <= '0;
          col_cnt  <= '0;
          row_cnt  <= '0;
        end else begin
          addr_cnt <= addr_cnt + 1'b1;
          if (col_cnt == COL_W'(IMG_W - 1)) begin
            col_cnt <= '0;
            row_cnt <= row_cnt + 1'b1;
          end else begin
            col_cnt <= col_cnt + 1'b1;
          end
        end
      end else if (clear_cnt) begin
        addr_cnt <= '0;
        col_cnt  <= '0;
        row_cnt  <= '0;
      end
      if ((state == FULL) && byte_evt) bus.overflow <= 1'b1;
    end
  end

`ifdef FRAME_CHECKSUM_EN
  logic [DATA_W-1:0] sum;

  // Sum includes the byte being written while memWe is high; cleared whenever the FSM returns to IDLE.
  always_ff @(posedge clk) begin
    if (!nRst)          sum <= '0;
    else if (write_go)  sum <= sum + bus.byteIn;
    else if (clear_cnt) sum <= '0;
  end

  always_comb begin
    bus.checksum      = sum;
    bus.checksumValid = (state == FULL);
  end
`endif
endmodule

// File: tb/tb_spi_frame_writer.sv
// Randomized self-checking bench for spi_frame_writer against a frame-fill reference model.
module tb_spi_frame_writer;
  localparam int DATA_W = 8;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 2;
  localparam int ADDR_W = 3;
  localparam int N      = IMG_W * IMG_H;

  logic clk  = 1'b0;
  logic nRst = 1'b0;
  always #5 clk = ~clk;

  spi_frame_writer_if #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) bus ();

  spi_frame_writer #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: bytes accepted so far in this frame, frame-complete flag, sticky overflow, running sum.
  int       fill = 0;
  bit       full = 1'b0;
  bit       ovf  = 1'b0;
  bit [7:0] sum  = 8'h00;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_ready"},    32'(bus.frameReady), 32'(full));
    check({tag, "_busy"},     32'((fill > 0) && !full), 32'(bus.busy));
    check({tag, "_overflow"}, 32'(bus.overflow),   32'(ovf));
  endtask

  // One strobe high for 4 clk (half of an 8x-slower spiClk), then 4 clk low.
  // With abort set, frameAbort is held during the cycle in which the byte event is seen.
  task automatic send_byte(input bit [7:0] b, input bit abort);
    bit       exp_w;
    int       exp_addr;
    bit       exp_last;
    bit [7:0] exp_sum;
    int       pulses;
    int       lat;
    exp_w    = !full && !abort;
    exp_addr = fill;
    exp_last = (fill == N - 1);
    exp_sum  = sum + b;
    pulses   = 0;
    lat      = 0;
    bus.byteIn     = b;
    bus.byteStrobe = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (bus.memWe) begin
        pulses++;
        if (pulses == 1) begin
          lat = k;
          check("addr",  32'(bus.memAddr),    32'(exp_addr));
          check("data",  32'(bus.memWdata),   32'(b));
          check("row",   32'(bus.row),        32'(exp_addr / IMG_W));
          check("col",   32'(bus.col),        32'(exp_addr % IMG_W));
          check("ready_at_write", 32'(bus.frameReady), 32'(exp_last));
          check("busy_at_write",  32'(bus.busy),       32'(!exp_last));
`ifdef FRAME_CHECKSUM_EN
          check("checksum",       32'(bus.checksum),      32'(exp_sum));
          check("checksum_valid", 32'(bus.checksumValid), 32'(exp_last));
`endif
        end
      end
      if (k == 2 && abort) bus.frameAbort = 1'b1;
      if (k == 3) bus.frameAbort = 1'b0;
      if (k == 4) begin
        bus.byteStrobe = 1'b0;
        bus.byteIn     = 8'($urandom);
      end
    end
    check("we_pulses", 32'(pulses), 32'(exp_w));
    if (exp_w) check("latency", 32'(lat), 32'd3);
    if (abort) begin
      fill = 0;
      sum  = 8'h00;
    end else if (full) begin
      ovf = 1'b1;
    end else begin
      sum  = exp_sum;
      fill = fill + 1;
      if (fill == N) begin
        full = 1'b1;
        fill = 0;
      end
    end
    check_status("after_byte");
  endtask

  task automatic pulse(input bit use_abort);
    if (use_abort) bus.frameAbort = 1'b1;
    else           bus.frameAck   = 1'b1;
    @(posedge clk); #1;
    bus.frameAbort = 1'b0;
    bus.frameAck   = 1'b0;
    if (full || use_abort) begin
      full = 1'b0;
      fill = 0;
      sum  = 8'h00;
    end
    check_status(use_abort ? "after_abort" : "after_ack");
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    32'(bus.memWe),      32'd0);
    check({tag, "_addr"},  32'(bus.memAddr),    32'd0);
    check({tag, "_data"},  32'(bus.memWdata),   32'd0);
    check({tag, "_col"},   32'(bus.col),        32'd0);
    check({tag, "_row"},   32'(bus.row),        32'd0);
    check({tag, "_ready"}, 32'(bus.frameReady), 32'd0);
    check({tag, "_busy"},  32'(bus.busy),       32'd0);
    check({tag, "_ovf"},   32'(bus.overflow),   32'd0);
  endtask

  initial begin
    bit [7:0] cs_bytes [N];
    int       r;
    bus.byteIn     = '0;
    bus.byteStrobe = 1'b0;
    bus.frameAbort = 1'b0;
    bus.frameAck   = 1'b0;
    nRst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    nRst = 1'b1;
    @(posedge clk); #1;

    // Full frame of 0x10..0x17, then a byte while FULL.
    for (int i = 0; i < N; i++) send_byte(8'(8'h10 + i), 1'b0);
    send_byte(8'hAA, 1'b0);
    pulse(1'b0);

    // New frame after ack, an ignored ack in FILL, then abort coincident with the 4th byte.
    send_byte(8'h55, 1'b0);
    pulse(1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'h57, 1'b0);
    send_byte(8'h58, 1'b1);
    send_byte(8'h59, 1'b0);

    // Reset after five writes discards the partial frame and the sticky overflow.
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0);
    nRst = 1'b0;
    @(posedge clk); #1;
    check_all_zero("midframe_reset");
    nRst = 1'b1;
    fill = 0;
    full = 1'b0;
    ovf  = 1'b0;
    sum  = 8'h00;
    @(posedge clk); #1;

    // Modulo-256 checksum frame: 0xFF + 0x02 wraps to 0x01.
    foreach (cs_bytes[i]) cs_bytes[i] = 8'h00;
    cs_bytes[0] = 8'hFF;
    cs_bytes[1] = 8'h02;
    foreach (cs_bytes[i]) send_byte(cs_bytes[i], 1'b0);
`ifdef FRAME_CHECKSUM_EN
    check("checksum_wrap",       32'(bus.checksum),      32'h01);
    check("checksum_wrap_valid", 32'(bus.checksumValid), 32'd1);
`endif
    pulse(1'b0);

    // Randomized mix of bytes, aborts and acks.
    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)       send_byte(8'($urandom), 1'b0);
      else if (r == 7) begin
        if (!full) send_byte(8'($urandom), 1'b1);
        else       pulse(1'b1);
      end
      else if (r == 8) pulse(1'b0);
      else             pulse(1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_frame_writer.md
Name: spi_frame_writer

Overview:
- Consumes the byte stream produced by the SPI receive stage (spiClk domain) and writes it into the image frame buffer on the system clock.
- Performs the clock-domain crossing of the byte strobe and generates linear and row/column addresses.
- Signals a complete frame to the edge-detection core, then holds off further writes until the core acknowledges.

Parameters:
- DATA_W, 8, pixel/byte width; must equal SPI message width.
- IMG_W, 64, pixels per row.
- IMG_H, 64, rows per frame.
- ADDR_W, 12, frame-buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.

Ports:
- clk  in  1  system clock; frequency >= 6x spiClk.
- nRst  in  1  reset, synchronous, active-low.
- byteIn  in  DATA_W  received byte from the SPI stage; stable while byteStrobe is high.
- byteStrobe  in  1  byte-done level from the SPI stage, asynchronous to clk, high for >= 1 spiClk period.
- frameAbort  in  1  synchronous clear of the current fill.
- frameAck  in  1  core has consumed the frame; single-cycle pulse.
- memWe  out  1  frame-buffer write enable.
- memAddr  out  ADDR_W  linear write address.
- memWdata  out  DATA_W  write data.
- col  out  $clog2(IMG_W)  column of the current write.
- row  out  $clog2(IMG_H)  row of the current write.
- frameReady  out  1  frame complete; held high until frameAck.
- busy  out  1  fill in progress (FILL state).
- overflow  out  1  sticky: a byte arrived while FULL.

Behaviour:
- Reset (nRst low at a clk edge): state IDLE, all counters 0, sync flops 0.
  - Outputs at reset: memWe=0, memAddr=0, memWdata=0, col=0, row=0, frameReady=0, busy=0, overflow=0.
  - Reset mid-frame discards the partial frame; no write is issued in the reset cycle.
- CDC:
  - byteStrobe passes through a 2-flop synchronizer (s1, s2) followed by a history flop s3.
  - byteEvt = s2 & ~s3; exactly one event per strobe high period.
  - byteIn is sampled into memWdata in the byteEvt cycle; no multi-bit synchronizer is needed because the data is stable.
- Write timing:
  - memWe is registered: high for exactly one clk, in the cycle after byteEvt.
  - memAddr, col and row present the address of that write while memWe is high.
  - Latency from byteStrobe rising to memWe high is 3-4 clk edges.
- FSM (IDLE, FILL, FULL):
  - IDLE: on byteEvt, write at address 0, go to FILL, busy=1.
  - FILL: each byteEvt writes at the next address. Counter advance: col increments; when col=IMG_W-1 it wraps to 0 and row increments.
  - FILL exit: on the write at address IMG_W*IMG_H-1, go to FULL. frameReady rises in the same cycle as that memWe; busy=0.
  - FULL: byteEvt causes no write and sets overflow. On frameAck, go to IDLE, reset counters, clear frameReady.
  - frameAck in IDLE or FILL is ignored.
- frameAbort:
  - In FILL: go to IDLE and zero counters. A byteEvt in the same cycle is dropped.
  - In FULL: frameAbort behaves like frameAck.
  - frameAbort takes priority over byteEvt and frameAck.
- overflow clears only on reset.
- Address arithmetic:
  - memAddr = row*IMG_W + col, kept as an incrementing counter with no multiplier.
  - memAddr never exceeds IMG_W*IMG_H-1.

Optional Feature:
- Macro: FRAME_CHECKSUM_EN.
- When defined, adds output checksum [DATA_W] and checksumValid [1]:
  - checksum is the modulo-2^DATA_W sum of all bytes written in the current frame.
  - It is cleared on entry to IDLE and updated with each memWe.
  - checksumValid equals frameReady.
- When undefined, neither port exists and no accumulator logic is present.

Test Plan (IMG_W=4, IMG_H=2, ADDR_W=3, clk = 8x spiClk):
- Reset, then 8 strobes with bytes 0x10..0x17 -> 8 single-cycle memWe pulses at addr 0..7; (row,col) runs (0,0)..(0,3),(1,0)..(1,3); frameReady rises with the addr-7 write; busy falls.
- In FULL, send a strobe with 0xAA -> no memWe; overflow=1 and stays 1 after frameAck.
- frameAck after a full frame, then byte 0x55 -> write at addr 0 with data 0x55; frameReady=0.
- 3 bytes, then frameAbort coincident with the 4th byteEvt -> no 4th write; state IDLE; the next byte writes at addr 0.
- nRst low after 5 writes -> all outputs 0 next cycle; the following frame starts at addr 0.
- FRAME_CHECKSUM_EN defined, bytes 0xFF,0x02,0,0,0,0,0,0 -> checksum=0x01 with checksumValid=1.
